bus_arbiter_n: RTL and testbench
================================

Name: bus_arbiter_n

Overview:
- Parametrised N-client arbiter sharing one single-outstanding request/ack server bus.
- Clients and server use the same handshake: rq, ack, wr_ni, address, dataW and dataR.
- Clients use packed vector ports. Scheduling is selectable between strict priority and round robin.
- The winning client's command is latched, so the server sees stable fields for the whole transaction.

Parameters:
- NUM_CLIENTS, 4: number of client ports; must be >= 2. Localparam ID_WIDTH = $clog2(NUM_CLIENTS).
- DATA_WIDTH, 8: data bus width.
- ADDR_WIDTH, 4: address width.
- PRIORITY_SCHEDULING_ALGORITHM, 0: 0 = strict priority (index 0 highest); 1 = round robin.
- TIMEOUT_CYCLES, 16: server ack timeout limit. Used only with ARB_TIMEOUT_EN; must be >= 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- srv_address  out  ADDR_WIDTH  latched address of the granted client.
- srv_rq  out  1  request to server; registered.
- srv_ack  in  1  server completion, one-cycle pulse.
- srv_wr_ni  out  1  1 = write, 0 = read; latched.
- srv_dataW  out  DATA_WIDTH  latched write data.
- srv_dataR  in  DATA_WIDTH  read data, valid with srv_ack.
- client_address  in  NUM_CLIENTS*ADDR_WIDTH  client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- client_rq  in  NUM_CLIENTS  per-client request.
- client_ack  out  NUM_CLIENTS  per-client one-cycle completion pulse; registered.
- client_wr_ni  in  NUM_CLIENTS  per-client write/read select.
- client_dataW  in  NUM_CLIENTS*DATA_WIDTH  client i at [i*DATA_WIDTH +: DATA_WIDTH].
- client_dataR  out  NUM_CLIENTS*DATA_WIDTH  per-client registered read data.
- grant_id  out  ID_WIDTH  index of the current or last granted client.
- busy  out  1  1 while in state BUSY or ACK.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; srv_rq, client_ack, busy = 0.
  - srv_address, srv_dataW, srv_wr_ni, client_dataR, grant_id = 0.
  - RR pointer last_grant = NUM_CLIENTS-1, so client 0 wins first.
  - Reset mid-transaction aborts it: srv_rq drops immediately, no ack is issued, and the pending transaction is lost.
- FSM IDLE -> BUSY:
  - When any client_rq bit is 1, pick winner g, latch its address/wr_ni/dataW into the srv_* registers, set grant_id = g, set srv_rq = 1, and go to BUSY.
  - Otherwise stay in IDLE with srv_rq = 0.
- FSM BUSY:
  - srv_rq stays 1 and srv_* fields stay stable.
  - On srv_ack = 1: srv_rq <= 0 and client_ack[g] <= 1.
  - If the transaction is a read, client_dataR slice g <= srv_dataR.
  - In RR mode, last_grant <= g. Then go to ACK.
- FSM ACK:
  - client_ack[g] is high for exactly this one cycle, then cleared. Go to IDLE.
- Latency:
  - client_rq sampled at edge n -> srv_rq high after edge n.
  - srv_ack sampled at edge m -> client_ack high for the cycle after edge m.
  - Minimum rq-to-ack is 2 cycles. One idle cycle separates back-to-back grants.
- Strict priority: the lowest-index requesting client wins. Starvation of high indices is permitted.
- Round robin:
  - Search starts at last_grant+1 and wraps modulo NUM_CLIENTS; the first requester found wins.
  - last_grant updates only on completion.
- Client contract:
  - Hold rq and all fields until ack.
  - A client still holding rq in the IDLE cycle after ACK starts a new transaction.
  - If the granted client drops rq during BUSY, the latched transaction still completes and the ack still pulses.
- Other rules:
  - srv_ack while not in BUSY is ignored.
  - A write never modifies client_dataR. Each dataR slice holds its value until that client's next read completes.
  - Non-granted clients' rq changes have no effect until IDLE.
  - Any NUM_CLIENTS that is not a power of two wraps correctly; grant_id never exceeds NUM_CLIENTS-1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - Add output port client_err, NUM_CLIENTS bits, reset 0.
  - A counter clears on entering BUSY and increments each BUSY cycle without srv_ack.
  - When TIMEOUT_CYCLES consecutive BUSY cycles pass with no srv_ack: srv_rq <= 0, and client_ack[g] and client_err[g] pulse together in ACK. client_dataR slice g is unchanged. RR pointer advances as normal.
  - srv_ack arriving in the same cycle as the counter limit counts as success.
- Without the macro: no port, no counter, and BUSY waits indefinitely.

Test Plan:
- Single read, client 2 (addr 0x5), srv_ack one cycle later with srv_dataR = 0xA7 -> srv_address = 0x5, srv_wr_ni = 0; client_ack[2] pulses once; client_dataR slice 2 = 0xA7; other slices stay 0.
- Strict mode, clients 0..3 all request, server acks each after 1 cycle, rq held continuously -> grant order 0,0,0... (client 0 monopolises); clients 1-3 never acked.
- RR mode, clients 0..3 all request writes with dataW = 0x10..0x13 -> srv_dataW sequence 0x10, 0x11, 0x12, 0x13, 0x10; each client_ack fires once per round.
- Client 1 write 0x3C; its rq drops in BUSY; srv_ack after 4 cycles -> srv_dataW stable = 0x3C throughout; client_ack[1] still pulses; client_dataR slice 1 unchanged.
- Reset asserted mid-BUSY -> srv_rq, busy, client_ack = 0 immediately; after release the next grant is client 0 in RR mode.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, server never acks -> client_ack[g] and client_err[g] pulse after 16 BUSY cycles; srv_rq = 0; dataR unchanged.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-client arbiter sharing one single-outstanding rq/ack server bus.
// Define ARB_TIMEOUT_EN to add a server-ack timeout and a per-client client_err pulse.
module bus_arbiter_n #(
  parameter  int NUM_CLIENTS                   = 4,
  parameter  int DATA_WIDTH                    = 8,
  parameter  int ADDR_WIDTH                    = 4,
  parameter  int PRIORITY_SCHEDULING_ALGORITHM = 0,
  parameter  int TIMEOUT_CYCLES                = 16,
  localparam int ID_WIDTH                      = $clog2(NUM_CLIENTS)
) (
  input  logic                              clk,
  input  logic                              reset,
  // server side
  output logic [ADDR_WIDTH-1:0]             srv_address,
  output logic                              srv_rq,
  input  logic                              srv_ack,
  output logic                              srv_wr_ni,
  output logic [DATA_WIDTH-1:0]             srv_dataW,
  input  logic [DATA_WIDTH-1:0]             srv_dataR,
  // client side, client i in slice i
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
  input  logic [NUM_CLIENTS-1:0]            client_rq,
  output logic [NUM_CLIENTS-1:0]            client_ack,
  input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataR,
`ifdef ARB_TIMEOUT_EN
  output logic [NUM_CLIENTS-1:0]            client_err,
`endif
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              busy
);

  if (NUM_CLIENTS < 2) begin : g_bad_num_clients
    $error("bus_arbiter_n: NUM_CLIENTS must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_arbiter_n: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_CLIENTS - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] cand;
  logic                any_rq;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TO_WIDTH-1:0] timeout_cnt;
`endif

  // Winner selection. Loops run from the lowest-preference candidate upwards so the
  // last assignment, i.e. the most preferred requester, wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner = '0;
    cand   = '0;
    any_rq = |client_rq;
    if (PRIORITY_SCHEDULING_ALGORITHM == 0) begin
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
        if (client_rq[i]) winner = ID_WIDTH'(i);
      end
    end else begin
      for (int k = NUM_CLIENTS; k >= 1; k--) begin
        cand = ID_WIDTH'((int'(last_grant) + k) % NUM_CLIENTS);
        if (client_rq[cand]) winner = cand;
      end
    end
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      srv_rq       <= 1'b0;
      srv_address  <= '0;
      srv_wr_ni    <= 1'b0;
      srv_dataW    <= '0;
      client_ack   <= '0;
      // NOTE: client_dataR is a visible output register bank, so it is reset like any flop.
      client_dataR <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      last_grant   <= LAST_ID;
`ifdef ARB_TIMEOUT_EN
      client_err   <= '0;
      timeout_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_rq) begin
            srv_address <= client_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            srv_dataW   <= client_dataW[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            srv_wr_ni   <= client_wr_ni[winner];
            grant_id    <= winner;
            srv_rq      <= 1'b1;
            busy        <= 1'b1;
            state       <= BUSY;
`ifdef ARB_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
        end

        BUSY: begin
          if (srv_ack) begin
            srv_rq               <= 1'b0;
            client_ack[grant_id] <= 1'b1;
            if (!srv_wr_ni) begin
              client_dataR[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] <= srv_dataR;
            end
            if (PRIORITY_SCHEDULING_ALGORITHM == 1) last_grant <= grant_id;
            state <= ACK;
          end
`ifdef ARB_TIMEOUT_EN
          // An ack on the limit cycle is handled above and counts as success.
          else if (timeout_cnt == TO_LAST) begin
            srv_rq               <= 1'b0;
            client_ack[grant_id] <= 1'b1;
            client_err[grant_id] <= 1'b1;
            if (PRIORITY_SCHEDULING_ALGORITHM == 1) last_grant <= grant_id;
            state <= ACK;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
`endif
        end

        ACK: begin
          client_ack <= '0;
`ifdef ARB_TIMEOUT_EN
          client_err <= '0;
`endif
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          srv_rq <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Testbench for bus_arbiter_n: one strict-priority and one round-robin instance, driven by
// directed and $urandom transactions and checked against a transaction-level model.
module tb_bus_arbiter_n;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int IW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: strict priority instance, index 1: round robin instance
  logic            rst_n       [2];
  logic [AW-1:0]   srv_address [2];
  logic            srv_rq      [2];
  logic            srv_ack     [2];
  logic            srv_wr_ni   [2];
  logic [DW-1:0]   srv_dataW   [2];
  logic [DW-1:0]   srv_dataR   [2];
  logic [N*AW-1:0] c_addr      [2];
  logic [N-1:0]    c_rq        [2];
  logic [N-1:0]    c_ack       [2];
  logic [N-1:0]    c_wr        [2];
  logic [N*DW-1:0] c_dw        [2];
  logic [N*DW-1:0] c_dr        [2];
  logic [IW-1:0]   gid         [2];
  logic            busy        [2];
`ifdef ARB_TIMEOUT_EN
  logic [N-1:0]    c_err       [2];
`endif

  bus_arbiter_n #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                  .PRIORITY_SCHEDULING_ALGORITHM(0), .TIMEOUT_CYCLES(TO)) u_strict (
    .clk(clk), .reset(rst_n[0]),
    .srv_address(srv_address[0]), .srv_rq(srv_rq[0]), .srv_ack(srv_ack[0]),
    .srv_wr_ni(srv_wr_ni[0]), .srv_dataW(srv_dataW[0]), .srv_dataR(srv_dataR[0]),
    .client_address(c_addr[0]), .client_rq(c_rq[0]), .client_ack(c_ack[0]),
    .client_wr_ni(c_wr[0]), .client_dataW(c_dw[0]), .client_dataR(c_dr[0]),
`ifdef ARB_TIMEOUT_EN
    .client_err(c_err[0]),
`endif
    .grant_id(gid[0]), .busy(busy[0])
  );

  bus_arbiter_n #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                  .PRIORITY_SCHEDULING_ALGORITHM(1), .TIMEOUT_CYCLES(TO)) u_rr (
    .clk(clk), .reset(rst_n[1]),
    .srv_address(srv_address[1]), .srv_rq(srv_rq[1]), .srv_ack(srv_ack[1]),
    .srv_wr_ni(srv_wr_ni[1]), .srv_dataW(srv_dataW[1]), .srv_dataR(srv_dataR[1]),
    .client_address(c_addr[1]), .client_rq(c_rq[1]), .client_ack(c_ack[1]),
    .client_wr_ni(c_wr[1]), .client_dataW(c_dw[1]), .client_dataR(c_dr[1]),
`ifdef ARB_TIMEOUT_EN
    .client_err(c_err[1]),
`endif
    .grant_id(gid[1]), .busy(busy[1])
  );

  // Reference model: per-client outstanding commands, per-client read data, RR pointer.
  bit            pend   [2][N];
  bit            m_wr   [2][N];
  logic [AW-1:0] m_addr [2][N];
  logic [DW-1:0] m_dw   [2][N];
  logic [DW-1:0] m_mem  [2][N];
  int            m_last [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strict: lowest requesting index. RR: first requester after the last completed grant.
  function automatic int exp_winner(input int m);
    if (m == 0) begin
      for (int i = 0; i < N; i++) if (pend[m][i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (pend[m][(m_last[m] + k) % N]) return (m_last[m] + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] exp_dr(input int m);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = m_mem[m][i];
    return v;
  endfunction

  task automatic drive(input int m);
    for (int i = 0; i < N; i++) begin
      c_rq[m][i]             = pend[m][i];
      c_wr[m][i]             = m_wr[m][i];
      c_addr[m][i*AW +: AW]  = m_addr[m][i];
      c_dw[m][i*DW +: DW]    = m_dw[m][i];
    end
  endtask

  task automatic model_reset(input int m);
    for (int i = 0; i < N; i++) m_mem[m][i] = '0;
    m_last[m] = N - 1;
  endtask

  task automatic clear_pend(input int m);
    for (int i = 0; i < N; i++) pend[m][i] = 1'b0;
    drive(m);
  endtask

  task automatic set_cmd(input int m, input int i, input bit wr, input int addr, input int dw);
    pend[m][i]   = 1'b1;
    m_wr[m][i]   = wr;
    m_addr[m][i] = AW'(addr);
    m_dw[m][i]   = DW'(dw);
  endtask

  // Randomly raise new requests on idle clients (never on client 'skip').
  task automatic refill(input int m, input int skip, input bit force_one);
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend[m][i] && i != skip && $urandom_range(1, 0) == 1)
        set_cmd(m, i, 1'($urandom), int'($urandom), int'($urandom));
      if (pend[m][i]) any = 1'b1;
    end
    if (force_one && !any) set_cmd(m, int'($urandom_range(N - 1, 0)), 1'($urandom),
                                   int'($urandom), int'($urandom));
    drive(m);
  endtask

  // One transaction. Entry and exit: at a negedge with the DUT in IDLE.
  task automatic run_txn(input int m, input int delay, input logic [DW-1:0] dr,
                         input bit keep, input bit drop, input bit churn, input bit stray);
    int            g;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ew;
    logic [N-1:0]  onehot;
    g = exp_winner(m);
    if (g < 0) begin
      check("no_requester", 1, 0);
      return;
    end
    ea = m_addr[m][g];
    ed = m_dw[m][g];
    ew = m_wr[m][g];
    onehot = N'(1) << g;
    @(posedge clk); @(negedge clk);
    check($sformatf("m%0d grant_id", m), gid[m], g);
    check($sformatf("m%0d srv_rq_up", m), srv_rq[m], 1);
    check($sformatf("m%0d busy_up", m), busy[m], 1);
    check($sformatf("m%0d srv_address", m), srv_address[m], ea);
    check($sformatf("m%0d srv_wr_ni", m), srv_wr_ni[m], ew);
    check($sformatf("m%0d srv_dataW", m), srv_dataW[m], ed);
    if (drop) begin
      pend[m][g]   = 1'b0;
      m_addr[m][g] = AW'($urandom);
      m_dw[m][g]   = DW'($urandom);
      drive(m);
    end
    if (churn) refill(m, g, 1'b0);
    for (int j = 0; j < delay; j++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("m%0d srv_rq_hold", m), srv_rq[m], 1);
      check($sformatf("m%0d ack_early", m), c_ack[m], 0);
      check($sformatf("m%0d addr_stable", m), srv_address[m], ea);
      check($sformatf("m%0d dataW_stable", m), srv_dataW[m], ed);
    end
    srv_ack[m]   = 1'b1;
    srv_dataR[m] = dr;
    @(posedge clk); @(negedge clk);
    srv_ack[m]   = 1'b0;
    srv_dataR[m] = DW'($urandom);
    if (!ew) m_mem[m][g] = dr;
    if (m == 1) m_last[m] = g;
    check($sformatf("m%0d srv_rq_down", m), srv_rq[m], 0);
    check($sformatf("m%0d client_ack", m), c_ack[m], onehot);
    check($sformatf("m%0d busy_ack", m), busy[m], 1);
    check($sformatf("m%0d client_dataR", m), c_dr[m], exp_dr(m));
`ifdef ARB_TIMEOUT_EN
    check($sformatf("m%0d client_err_ok", m), c_err[m], 0);
`endif
    if (!keep) pend[m][g] = 1'b0;
    drive(m);
    if (stray) srv_ack[m] = 1'b1;
    @(posedge clk); @(negedge clk);
    srv_ack[m] = 1'b0;
    check($sformatf("m%0d ack_cleared", m), c_ack[m], 0);
    check($sformatf("m%0d busy_idle", m), busy[m], 0);
    check($sformatf("m%0d srv_rq_idle", m), srv_rq[m], 0);
    check($sformatf("m%0d dataR_after", m), c_dr[m], exp_dr(m));
  endtask

  task automatic check_reset_values(input int m);
    check($sformatf("m%0d rst srv_rq", m), srv_rq[m], 0);
    check($sformatf("m%0d rst busy", m), busy[m], 0);
    check($sformatf("m%0d rst client_ack", m), c_ack[m], 0);
    check($sformatf("m%0d rst grant_id", m), gid[m], 0);
    check($sformatf("m%0d rst srv_address", m), srv_address[m], 0);
    check($sformatf("m%0d rst srv_dataW", m), srv_dataW[m], 0);
    check($sformatf("m%0d rst srv_wr_ni", m), srv_wr_ni[m], 0);
    check($sformatf("m%0d rst client_dataR", m), c_dr[m], 0);
  endtask

  task automatic test_dut(input int m);
    // single read by client 2
    clear_pend(m);
    set_cmd(m, 2, 1'b0, 5, int'($urandom));
    drive(m);
    run_txn(m, 1, 8'hA7, 0, 0, 0, 0);
    check($sformatf("m%0d dataR slice2", m), c_dr[m][2*DW +: DW], 8'hA7);

    // all four request continuously: strict monopolised by 0, RR rotates
    clear_pend(m);
    for (int i = 0; i < N; i++) set_cmd(m, i, 1'b1, i, 8'h10 + i);
    drive(m);
    for (int t = 0; t < 5; t++) run_txn(m, 1, DW'($urandom), 1, 0, 0, 0);

    // client 1 write 0x3C, rq dropped during BUSY, ack after 4 cycles
    clear_pend(m);
    set_cmd(m, 1, 1'b1, int'($urandom), 8'h3C);
    drive(m);
    run_txn(m, 4, DW'($urandom), 0, 1, 0, 0);

    // ack on the 16th BUSY cycle still completes normally
    clear_pend(m);
    set_cmd(m, 3, 1'b0, int'($urandom), int'($urandom));
    drive(m);
    run_txn(m, TO - 1, DW'($urandom), 0, 0, 0, 0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      refill(m, -1, 1'b1);
      run_txn(m, int'($urandom_range(3, 0)), DW'($urandom), 0,
              $urandom_range(3, 0) == 0, 1'($urandom), $urandom_range(2, 0) == 0);
    end

    // reset in the middle of BUSY
    for (int i = 0; i < N; i++) set_cmd(m, i, 1'($urandom), int'($urandom), int'($urandom));
    drive(m);
    @(posedge clk); @(negedge clk);
    check($sformatf("m%0d pre-reset srv_rq", m), srv_rq[m], 1);
    #2 rst_n[m] = 1'b0;
    #1 check_reset_values(m);
    model_reset(m);
    @(negedge clk);
    rst_n[m] = 1'b1;
    run_txn(m, 0, DW'($urandom), 0, 0, 0, 0);

`ifdef ARB_TIMEOUT_EN
    begin
      int g;
      clear_pend(m);
      set_cmd(m, 2, 1'b0, int'($urandom), int'($urandom));
      drive(m);
      g = exp_winner(m);
      @(posedge clk); @(negedge clk);
      check($sformatf("m%0d to grant", m), gid[m], g);
      for (int j = 0; j < TO - 1; j++) begin
        @(posedge clk); @(negedge clk);
        check($sformatf("m%0d to waiting", m), srv_rq[m], 1);
      end
      @(posedge clk); @(negedge clk);
      if (m == 1) m_last[m] = g;
      check($sformatf("m%0d to srv_rq", m), srv_rq[m], 0);
      check($sformatf("m%0d to ack", m), c_ack[m], N'(1) << g);
      check($sformatf("m%0d to err", m), c_err[m], N'(1) << g);
      check($sformatf("m%0d to dataR", m), c_dr[m], exp_dr(m));
      clear_pend(m);
      @(posedge clk); @(negedge clk);
      check($sformatf("m%0d to err clear", m), c_err[m], 0);
      check($sformatf("m%0d to ack clear", m), c_ack[m], 0);
    end
`endif
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      rst_n[m]     = 1'b0;
      srv_ack[m]   = 1'b0;
      srv_dataR[m] = '0;
      for (int i = 0; i < N; i++) begin
        pend[m][i]   = 1'b0;
        m_wr[m][i]   = 1'b0;
        m_addr[m][i] = '0;
        m_dw[m][i]   = '0;
      end
      model_reset(m);
      drive(m);
    end
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) check_reset_values(m);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    test_dut(0);
    test_dut(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
